trig_conditioner: RTL

- Front-end trigger stage feeding the RF pulse-sequence controller's `trig` input.
- Source is either an asynchronous external trigger (laser/AWG sync) or an internal repetition-rate generator.
- Synchronises and debounces the source, then issues a clean single-cycle `trig`.
- Enforces arming, a holdoff after each fire, and a controller-busy interlock; counts missed triggers.

---
 rtl/trig_conditioner.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/trig_conditioner.sv
// trig_conditioner: synchronised/debounced external or internal-rate trigger with arming, holdoff, busy interlock and missed count.
// Optional: define TRIG_TIMESTAMP_EN to latch a free-running cycle count into ts_out on every fire (ts_out is 0 otherwise).
module trig_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLDOFF_CYCLES  = 333,
    parameter int PERIOD_W        = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                trig_in,
    input  logic                src_sel,
    input  logic [PERIOD_W-1:0] period,
    input  logic                arm,
    input  logic                busy,
    input  logic                clr_missed,
    output logic                trig,
    output logic                armed,
    output logic [15:0]         missed_cnt,
    output logic [31:0]         ts_out
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, FIRE, HOLDOFF} state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DW-1:0]          r_deb_cnt;
    logic                   r_filt;
    logic                   r_filt_q;
    logic                   r_src_q;
    logic [PERIOD_W-1:0]    r_per_cnt;
    logic [HW-1:0]          r_hold_cnt;
    state_t                 r_state;
    logic                   r_trig;
    logic                   r_armed;
    logic [15:0]            r_missed;

    logic w_synced;
    logic w_src_chg;
    logic w_int_act;
    logic w_int_evt;
    logic w_ext_evt;
    logic w_evt;
    logic w_miss;

    assign w_synced  = r_sync[SYNC_STAGES-1];
    assign w_src_chg = src_sel != r_src_q;
    assign w_int_act = src_sel & (period != '0) & arm & ~w_src_chg;
    assign w_int_evt = w_int_act & (r_per_cnt == period - PERIOD_W'(1));
    assign w_ext_evt = r_filt & ~r_filt_q;
    assign w_evt     = ~w_src_chg & (src_sel ? w_int_evt : w_ext_evt);
    assign w_miss    = arm & w_evt & (((r_state == WAIT) & busy) | (r_state == FIRE) | (r_state == HOLDOFF));

    // Synchroniser and debounce filter; a source switch re-aligns the filter so no false edge appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_deb_cnt <= '0;
            r_filt    <= 1'b0;
            r_filt_q  <= 1'b0;
            r_src_q   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], trig_in};
            r_src_q <= src_sel;
            if (w_src_chg) begin
                r_deb_cnt <= '0;
                r_filt    <= w_synced;
                r_filt_q  <= w_synced;
            end else begin
                r_filt_q <= r_filt;
                if (r_deb_cnt == DEB_MAX) begin
                    r_filt    <= ~r_filt;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= (w_synced != r_filt) ? r_deb_cnt + 1'b1 : '0;
                end
            end
        end
    end

    // Internal repetition counter: runs 0..period-1 only while selected, enabled and armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_per_cnt <= '0;
        else        r_per_cnt <= (!w_int_act || w_int_evt) ? '0 : r_per_cnt + 1'b1;
    end

    // Arm/fire/holdoff state machine with registered trig and armed outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_trig     <= 1'b0;
            r_armed    <= 1'b0;
        end else if (!arm) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_trig     <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_trig  <= 1'b0;
            r_armed <= 1'b1;
            case (r_state)
                IDLE: r_state <= WAIT;
                WAIT: begin
                    if (w_evt && !busy) begin
                        r_state <= FIRE;
                        r_trig  <= 1'b1;
                    end
                end
                FIRE: begin
                    r_state    <= HOLDOFF;
                    r_hold_cnt <= '0;
                end
                HOLDOFF: begin
                    if (r_hold_cnt == HOLD_LAST) r_state <= WAIT;
                    else                         r_hold_cnt <= r_hold_cnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Saturating count of events rejected while armed; clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_missed <= '0;
        else        r_missed <= clr_missed ? '0 : (w_miss && r_missed != 16'hFFFF) ? r_missed + 1'b1 : r_missed;
    end

`ifdef TRIG_TIMESTAMP_EN
    logic [31:0] r_cycle;
    logic [31:0] r_ts;

    // Free-running cycle counter, captured into the timestamp during the FIRE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle <= '0;
            r_ts    <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
            if (r_state == FIRE) r_ts <= r_cycle;
        end
    end

    assign ts_out = r_ts;
`else
    assign ts_out = '0;
`endif

    assign trig       = r_trig;
    assign armed      = r_armed;
    assign missed_cnt = r_missed;
endmodule
